ddr_axi_arbiter: RTL and testbench

Shares the single AXI4 slave port of the DDR3 memory controller between two requesters. Port 0 is the memory management unit data path; port 1 is the instruction-fetch / code-RAM loader. The block arbitrates round-robin and sequences one single-beat 128-bit AXI read or write at a time. It returns completion, read data and error to the winning requester.

---
 rtl/ddr_axi_arbiter_if.sv | 100 ++++++++++
 rtl/ddr_axi_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_ddr_axi_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_axi_arbiter_if.sv
// Signal bundle for ddr_axi_arbiter: two requester ports plus the AXI4 port
// toward the DDR3 controller.
interface ddr_axi_arbiter_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ID_W   = 4
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // requester 0 (MMU data path)
  logic              m0_valid;
  logic              m0_ready;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [STRB_W-1:0] m0_wstrb;
  logic              m0_done;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_err;

  // requester 1 (instruction fetch / code-RAM loader)
  logic              m1_valid;
  logic              m1_ready;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [STRB_W-1:0] m1_wstrb;
  logic              m1_done;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;

  // AXI4 write address / data / response
  logic [ID_W-1:0]   s_axi_awid;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic [7:0]        s_axi_awlen;
  logic [2:0]        s_axi_awsize;
  logic [1:0]        s_axi_awburst;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [DATA_W-1:0] s_axi_wdata;
  logic [STRB_W-1:0] s_axi_wstrb;
  logic              s_axi_wlast;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic              s_axi_bready;
  logic [ID_W-1:0]   s_axi_bid;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;

  // AXI4 read address / data
  logic [ID_W-1:0]   s_axi_arid;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [7:0]        s_axi_arlen;
  logic [2:0]        s_axi_arsize;
  logic [1:0]        s_axi_arburst;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic              s_axi_rready;
  logic [ID_W-1:0]   s_axi_rid;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              s_axi_rvalid;

  // Arbiter view: serves both requesters and masters the AXI port.
  modport master (
    input  m0_valid, m0_we, m0_addr, m0_wdata, m0_wstrb,
    output m0_ready, m0_done, m0_rdata, m0_err,
    input  m1_valid, m1_we, m1_addr, m1_wdata, m1_wstrb,
    output m1_ready, m1_done, m1_rdata, m1_err,
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    output s_axi_bready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    output s_axi_rready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );

  // Environment view: the requesters plus the memory controller AXI slave.
  modport slave (
    output m0_valid, m0_we, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ready, m0_done, m0_rdata, m0_err,
    output m1_valid, m1_we, m1_addr, m1_wdata, m1_wstrb,
    input  m1_ready, m1_done, m1_rdata, m1_err,
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    input  s_axi_bready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    input  s_axi_rready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );
endinterface

// File: rtl/ddr_axi_arbiter.sv
// Round-robin arbiter sharing the DDR3 controller AXI4 slave port between two
// requesters; one single-beat 128-bit read or write in flight at a time.
module ddr_axi_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  ddr_axi_arbiter_if.master bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LINE_W = ADDR_W - 4;

  typedef enum logic [2:0] {IDLE, WR, BWAIT, RD, RWAIT, DONE} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_q, grant_d;
  logic [LINE_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                m0_done_q, m0_done_d;
  logic                m1_done_q, m1_done_d;
  logic                m0_err_q, m0_err_d;
  logic                m1_err_q, m1_err_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

  logic                gnt_c;
  logic                accept_c;
  logic [ID_W-1:0]     id_c;
  logic                aw_hs_c;
  logic                w_hs_c;
  logic                fin_c;
  logic                fin_err_c;
  logic                unused_c;

  // Grant: a lone requester wins; on a tie the port that did not win last time.
  assign gnt_c    = (bus.m0_valid && bus.m1_valid) ? ~last_grant_q : bus.m1_valid;
  assign accept_c = (state_q == IDLE) && (bus.m0_valid || bus.m1_valid) && !rst;
  assign id_c     = ID_W'(grant_q);

  // Handshake to requesters is same-cycle; ready is forced low during reset.
  assign bus.m0_ready = accept_c && !gnt_c;
  assign bus.m1_ready = accept_c && gnt_c;
  assign bus.m0_done  = m0_done_q;
  assign bus.m1_done  = m1_done_q;
  assign bus.m0_err   = m0_err_q;
  assign bus.m1_err   = m1_err_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;

  // AXI payloads: single 16-byte INCR beat, requester index in the ID LSB.
  assign bus.s_axi_awid    = id_c;
  assign bus.s_axi_awaddr  = {addr_q, 4'b0000};
  assign bus.s_axi_awlen   = 8'd0;
  assign bus.s_axi_awsize  = 3'b100;
  assign bus.s_axi_awburst = 2'b01;
  assign bus.s_axi_awvalid = awvalid_q;
  assign bus.s_axi_wdata   = wdata_q;
  assign bus.s_axi_wstrb   = wstrb_q;
  assign bus.s_axi_wlast   = 1'b1;
  assign bus.s_axi_wvalid  = wvalid_q;
  assign bus.s_axi_bready  = bready_q;
  assign bus.s_axi_arid    = id_c;
  assign bus.s_axi_araddr  = {addr_q, 4'b0000};
  assign bus.s_axi_arlen   = 8'd0;
  assign bus.s_axi_arsize  = 3'b100;
  assign bus.s_axi_arburst = 2'b01;
  assign bus.s_axi_arvalid = arvalid_q;
  assign bus.s_axi_rready  = rready_q;

  // Sub-line address bits and the OKAY/EXOKAY distinction carry no meaning here.
  assign unused_c = ^{bus.m0_addr[3:0], bus.m1_addr[3:0],
                      bus.s_axi_bresp[0], bus.s_axi_rresp[0]};

  // Next-state and registered-output computation for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    m0_done_d    = 1'b0;
    m1_done_d    = 1'b0;
    m0_err_d     = m0_err_q;
    m1_err_d     = m1_err_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    aw_hs_c      = awvalid_q && bus.s_axi_awready;
    w_hs_c       = wvalid_q && bus.s_axi_wready;
    fin_c        = 1'b0;
    fin_err_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          grant_d   = gnt_c;
          addr_d    = gnt_c ? bus.m1_addr[ADDR_W-1:4] : bus.m0_addr[ADDR_W-1:4];
          wdata_d   = gnt_c ? bus.m1_wdata : bus.m0_wdata;
          wstrb_d   = gnt_c ? bus.m1_wstrb : bus.m0_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (gnt_c ? bus.m1_we : bus.m0_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD;
          end
        end
      end
      WR: begin
        if (aw_hs_c) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs_c) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs_c) && (w_done_q || w_hs_c)) begin
          bready_d = 1'b1;
          state_d  = BWAIT;
        end
      end
      BWAIT: begin
        if (bus.s_axi_bvalid && bready_q) begin
          bready_d  = 1'b0;
          fin_c     = 1'b1;
          fin_err_c = bus.s_axi_bresp[1] || (bus.s_axi_bid != id_c);
        end
      end
      RD: begin
        if (arvalid_q && bus.s_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RWAIT;
        end
      end
      RWAIT: begin
        // non-last beats are swallowed so a malformed burst cannot wedge us
        if (bus.s_axi_rvalid && rready_q && bus.s_axi_rlast) begin
          rready_d  = 1'b0;
          fin_c     = 1'b1;
          fin_err_c = bus.s_axi_rresp[1] || (bus.s_axi_rid != id_c);
          if (grant_q) begin
            m1_rdata_d = bus.s_axi_rdata;
          end else begin
            m0_rdata_d = bus.s_axi_rdata;
          end
        end
      end
      DONE: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fin_c) begin
      state_d = DONE;
      if (grant_q) begin
        m1_done_d = 1'b1;
        m1_err_d  = fin_err_c;
      end else begin
        m0_done_d = 1'b1;
        m0_err_d  = fin_err_c;
      end
    end
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      m0_done_q    <= 1'b0;
      m1_done_q    <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      m0_done_q    <= m0_done_d;
      m1_done_q    <= m1_done_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end
endmodule

// File: tb/tb_ddr_axi_arbiter.sv
// Directed bench for ddr_axi_arbiter: the bench plays both requesters and the
// DDR controller AXI slave, stepping cycle by cycle.
module tb_ddr_axi_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  ddr_axi_arbiter_if bus ();

  ddr_axi_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Safety net in case a wait loop is ever broken.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise one requester's valid at an IDLE cycle, expect acceptance, then drop it.
  task automatic request(input bit p, input bit we, input logic [27:0] addr,
                         input logic [127:0] wdata, input logic [15:0] wstrb);
    if (p) begin
      bus.m1_valid = 1'b1; bus.m1_we = we; bus.m1_addr = addr;
      bus.m1_wdata = wdata; bus.m1_wstrb = wstrb;
    end else begin
      bus.m0_valid = 1'b1; bus.m0_we = we; bus.m0_addr = addr;
      bus.m0_wdata = wdata; bus.m0_wstrb = wstrb;
    end
    #1;
    chk("req_ready", p ? bus.m1_ready : bus.m0_ready, 1'b1);
    chk("req_other_ready", p ? bus.m0_ready : bus.m1_ready, 1'b0);
    step();
    chk("ready_one_cycle", p ? bus.m1_ready : bus.m0_ready, 1'b0);
    if (p) bus.m1_valid = 1'b0;
    else   bus.m0_valid = 1'b0;
  endtask

  // AXI slave for a write: independent AW/W ready delays, then one B beat.
  task automatic serve_write(input int aw_dly, input int w_dly, input logic [27:0] addr,
                             input logic [1:0] resp, input logic [3:0] id);
    int aw_n = 0;
    int w_n  = 0;
    int bad  = 0;
    int c    = 0;
    while (!bus.s_axi_awvalid && c < 20) begin step(); c++; end
    chk("awvalid_rise", bus.s_axi_awvalid, 1'b1);
    chk("wvalid_rise", bus.s_axi_wvalid, 1'b1);
    for (int k = 0; k < 12; k++) begin
      if (bus.s_axi_bready && (aw_n == 0 || w_n == 0)) bad++;
      if (bus.s_axi_awvalid && bus.s_axi_awaddr !== addr) bad++;
      bus.s_axi_awready = bus.s_axi_awvalid && (k >= aw_dly);
      bus.s_axi_wready  = bus.s_axi_wvalid && (k >= w_dly);
      if (bus.s_axi_awready) aw_n++;
      if (bus.s_axi_wready)  w_n++;
      step();
    end
    bus.s_axi_awready = 1'b0;
    bus.s_axi_wready  = 1'b0;
    chk("aw_handshakes", 128'(aw_n), 128'd1);
    chk("w_handshakes", 128'(w_n), 128'd1);
    chk("early_bready_or_unstable_addr", 128'(bad), 128'd0);
    chk("bready", bus.s_axi_bready, 1'b1);
    bus.s_axi_bvalid = 1'b1;
    bus.s_axi_bresp  = resp;
    bus.s_axi_bid    = id;
    step();
    bus.s_axi_bvalid = 1'b0;
  endtask

  // AXI slave for a read: immediate arready, then 'beats' R beats (last carries d).
  task automatic serve_read(input logic [127:0] d, input logic [1:0] resp,
                            input logic [3:0] id, input int beats);
    int c = 0;
    while (!bus.s_axi_arvalid && c < 20) begin step(); c++; end
    chk("arvalid_rise", bus.s_axi_arvalid, 1'b1);
    bus.s_axi_arready = 1'b1;
    step();
    bus.s_axi_arready = 1'b0;
    chk("arvalid_drop", bus.s_axi_arvalid, 1'b0);
    chk("rready", bus.s_axi_rready, 1'b1);
    chk("busy_m0_ready", bus.m0_ready, 1'b0);
    chk("busy_m1_ready", bus.m1_ready, 1'b0);
    for (int b = 0; b < beats; b++) begin
      bus.s_axi_rvalid = 1'b1;
      bus.s_axi_rdata  = (b == beats - 1) ? d : ~d;
      bus.s_axi_rlast  = (b == beats - 1);
      bus.s_axi_rresp  = resp;
      bus.s_axi_rid    = id;
      step();
    end
    bus.s_axi_rvalid = 1'b0;
    bus.s_axi_rlast  = 1'b0;
  endtask

  // At the DONE cycle: pulse on the right port, error/data state, then pulse ends.
  task automatic expect_done(input bit p, input logic e0, input logic e1,
                             input logic [127:0] r0, input logic [127:0] r1);
    chk("done_port", p ? bus.m1_done : bus.m0_done, 1'b1);
    chk("done_other", p ? bus.m0_done : bus.m1_done, 1'b0);
    chk("m0_err", bus.m0_err, e0);
    chk("m1_err", bus.m1_err, e1);
    chk("m0_rdata", bus.m0_rdata, r0);
    chk("m1_rdata", bus.m1_rdata, r1);
    step();
    chk("done_pulse_end", bus.m0_done | bus.m1_done, 1'b0);
  endtask

  initial begin
    logic [127:0] r0;
    logic [127:0] r1;
    logic [127:0] d;
    logic         e0;
    logic         e1;
    int           n0;
    int           n1;
    bit           ep;

    r0 = '0; r1 = '0; e0 = 1'b0; e1 = 1'b0; n0 = 0; n1 = 0;
    rst = 1'b1;
    bus.m0_valid = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wstrb = '0;
    bus.m1_valid = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wstrb = '0;
    bus.s_axi_awready = 1'b0; bus.s_axi_wready = 1'b0;
    bus.s_axi_bvalid = 1'b0; bus.s_axi_bresp = '0; bus.s_axi_bid = '0;
    bus.s_axi_arready = 1'b0;
    bus.s_axi_rvalid = 1'b0; bus.s_axi_rdata = '0; bus.s_axi_rresp = '0;
    bus.s_axi_rid = '0; bus.s_axi_rlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // reset state
    chk("rst_awvalid", bus.s_axi_awvalid, 1'b0);
    chk("rst_wvalid", bus.s_axi_wvalid, 1'b0);
    chk("rst_arvalid", bus.s_axi_arvalid, 1'b0);
    chk("rst_bready", bus.s_axi_bready, 1'b0);
    chk("rst_rready", bus.s_axi_rready, 1'b0);
    chk("rst_m0_ready", bus.m0_ready, 1'b0);
    chk("rst_m1_ready", bus.m1_ready, 1'b0);
    chk("rst_m0_done", bus.m0_done, 1'b0);
    chk("rst_m1_done", bus.m1_done, 1'b0);
    chk("rst_m0_err", bus.m0_err, 1'b0);
    chk("rst_m1_err", bus.m1_err, 1'b0);
    chk("rst_m0_rdata", bus.m0_rdata, 128'd0);
    chk("rst_m1_rdata", bus.m1_rdata, 128'd0);
    step();

    // single write from port 0
    request(1'b0, 1'b1, 28'h0000123, {16{8'hA5}}, 16'hFFFF);
    chk("wr_awaddr", bus.s_axi_awaddr, 28'h0000120);
    chk("wr_awlen", bus.s_axi_awlen, 8'd0);
    chk("wr_awsize", bus.s_axi_awsize, 3'b100);
    chk("wr_awburst", bus.s_axi_awburst, 2'b01);
    chk("wr_awid", bus.s_axi_awid, 4'd0);
    chk("wr_wlast", bus.s_axi_wlast, 1'b1);
    chk("wr_wdata", bus.s_axi_wdata, {16{8'hA5}});
    chk("wr_wstrb", bus.s_axi_wstrb, 16'hFFFF);
    serve_write(0, 0, 28'h0000120, 2'b00, 4'd0);
    expect_done(1'b0, e0, e1, r0, r1);

    // single read from port 1
    request(1'b1, 1'b0, 28'h0000040, '0, '0);
    chk("rd_arid", bus.s_axi_arid, 4'd1);
    chk("rd_araddr", bus.s_axi_araddr, 28'h0000040);
    chk("rd_arlen", bus.s_axi_arlen, 8'd0);
    chk("rd_arsize", bus.s_axi_arsize, 3'b100);
    chk("rd_arburst", bus.s_axi_arburst, 2'b01);
    d = 128'h0123456789ABCDEF0123456789ABCDEF;
    serve_read(d, 2'b00, 4'd1, 1);
    r1 = d;
    expect_done(1'b1, e0, e1, r0, r1);
    step();
    chk("rd_m1_rdata_held", bus.m1_rdata, d);

    // contention: both ports stream 4 reads; grants alternate starting with port 0
    for (int i = 0; i < 8; i++) begin
      ep = (i % 2 == 1);
      bus.m0_valid = (n0 < 4); bus.m0_we = 1'b0; bus.m0_addr = 28'h0001000;
      bus.m1_valid = (n1 < 4); bus.m1_we = 1'b0; bus.m1_addr = 28'h0002000;
      #1;
      chk("cont_m0_ready", bus.m0_ready, !ep);
      chk("cont_m1_ready", bus.m1_ready, ep);
      step();
      chk("cont_arid", bus.s_axi_arid, 4'(ep));
      d = 128'hFACE0000000000000000000000000000 | 128'(i + 1);
      serve_read(d, 2'b00, 4'(ep), 1);
      if (ep) begin r1 = d; n1++; end
      else    begin r0 = d; n0++; end
      expect_done(ep, e0, e1, r0, r1);
    end
    bus.m0_valid = 1'b0;
    bus.m1_valid = 1'b0;
    chk("cont_served_m0", 128'(n0), 128'd4);
    chk("cont_served_m1", 128'(n1), 128'd4);

    // channel skew: W before AW, AW before W, both together
    request(1'b0, 1'b1, 28'h0000310, {16{8'h3C}}, 16'h00FF);
    serve_write(5, 0, 28'h0000310, 2'b00, 4'd0);
    expect_done(1'b0, e0, e1, r0, r1);
    request(1'b0, 1'b1, 28'h0000320, {16{8'h4D}}, 16'hFF00);
    serve_write(0, 5, 28'h0000320, 2'b00, 4'd0);
    expect_done(1'b0, e0, e1, r0, r1);
    request(1'b0, 1'b1, 28'h0000330, {16{8'h5E}}, 16'h0F0F);
    serve_write(2, 2, 28'h0000330, 2'b00, 4'd0);
    expect_done(1'b0, e0, e1, r0, r1);

    // errors: SLVERR write, DECERR read, ID mismatch read, then clean traffic
    request(1'b0, 1'b1, 28'h0000400, '1, 16'hFFFF);
    serve_write(0, 0, 28'h0000400, 2'b10, 4'd0);
    e0 = 1'b1;
    expect_done(1'b0, e0, e1, r0, r1);

    request(1'b1, 1'b0, 28'h0000410, '0, '0);
    d = 128'hDEAD0000000000000000000000000001;
    serve_read(d, 2'b11, 4'd1, 1);
    r1 = d; e1 = 1'b1;
    expect_done(1'b1, e0, e1, r0, r1);

    request(1'b0, 1'b0, 28'h0000420, '0, '0);
    d = 128'hBEEF0000000000000000000000000002;
    serve_read(d, 2'b00, 4'd1, 1);
    r0 = d; e0 = 1'b1;
    expect_done(1'b0, e0, e1, r0, r1);

    // clean read arriving as a malformed two-beat burst; only the last beat counts
    request(1'b1, 1'b0, 28'h0000430, '0, '0);
    d = 128'hC0DE0000000000000000000000000003;
    serve_read(d, 2'b00, 4'd1, 2);
    r1 = d; e1 = 1'b0;
    expect_done(1'b1, e0, e1, r0, r1);

    // clean write leaves port 0 read data untouched
    request(1'b0, 1'b1, 28'h0000440, {16{8'h11}}, 16'hFFFF);
    serve_write(0, 0, 28'h0000440, 2'b00, 4'd0);
    e0 = 1'b0;
    expect_done(1'b0, e0, e1, r0, r1);

    // reset while waiting for read data (last winner was port 0)
    request(1'b1, 1'b0, 28'h0000500, '0, '0);
    bus.s_axi_arready = 1'b1;
    step();
    bus.s_axi_arready = 1'b0;
    chk("pre_rst_rready", bus.s_axi_rready, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rready", bus.s_axi_rready, 1'b0);
    chk("mid_rst_arvalid", bus.s_axi_arvalid, 1'b0);
    chk("mid_rst_m1_done", bus.m1_done, 1'b0);
    chk("mid_rst_m0_rdata", bus.m0_rdata, 128'd0);
    chk("mid_rst_m0_err", bus.m0_err, 1'b0);
    chk("mid_rst_m1_rdata", bus.m1_rdata, 128'd0);
    r0 = '0; r1 = '0; e0 = 1'b0; e1 = 1'b0;
    bus.s_axi_rvalid = 1'b1; bus.s_axi_rlast = 1'b1; bus.s_axi_rid = 4'd1;
    bus.s_axi_rdata = '1;
    step();
    bus.s_axi_rvalid = 1'b0; bus.s_axi_rlast = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_no_done", bus.m0_done | bus.m1_done, 1'b0);
      chk("post_rst_no_valid", bus.s_axi_arvalid | bus.s_axi_awvalid, 1'b0);
      step();
    end

    // tie after reset: port 0 wins, then port 1 is served next
    bus.m0_valid = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 28'h0000600;
    bus.m1_valid = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 28'h0000610;
    #1;
    chk("tie_m0_ready", bus.m0_ready, 1'b1);
    chk("tie_m1_ready", bus.m1_ready, 1'b0);
    step();
    bus.m0_valid = 1'b0;
    chk("tie_arid", bus.s_axi_arid, 4'd0);
    d = 128'h600D0000000000000000000000000006;
    serve_read(d, 2'b00, 4'd0, 1);
    r0 = d;
    expect_done(1'b0, e0, e1, r0, r1);
    chk("next_m1_ready", bus.m1_ready, 1'b1);
    step();
    bus.m1_valid = 1'b0;
    chk("next_arid", bus.s_axi_arid, 4'd1);
    d = 128'h600D0000000000000000000000000007;
    serve_read(d, 2'b00, 4'd1, 1);
    r1 = d;
    expect_done(1'b1, e0, e1, r0, r1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
